led_sequencer: RTL and testbench

LED_SEQUENCER -- requirements
Module: led_sequencer

---
 rtl/led_sequencer.sv | 168 ++++++++++++++++
 tb/tb_led_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_sequencer.sv
// LED pattern sequencer: steps an 8-bit pattern (rotate, bounce, count or LFSR)
// on rising edges of a selectable tap of an upstream free-running counter.
module led_sequencer #(
  parameter int CNT_W = 16,
  parameter int LED_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] currentCount,
  input  logic [1:0]       rate_sel,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic             stop,
  output logic [LED_W-1:0] leds,
  output logic             busy,
  output logic             running,
  output logic             wrap
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] leds_q, leds_d;
  logic [7:0] step_q, step_d;
  logic [1:0] mode_q, mode_d;
  logic       dir_right_q, dir_right_d;
  logic       prev_tap_q, prev_tap_d;
  logic       wrap_q, wrap_d;
  logic       busy_q, busy_d;
  logic       running_q, running_d;

  logic [CNT_W-1:0] count_unused;
  logic [3:0]       taps;
  logic             tap;
  logic             tick;
  logic [8:0]       step_inc;
  logic [7:0]       next_pat;
  logic             next_dir_right;

  function automatic logic [7:0] seed_of(input logic [1:0] m);
    return (m == 2'd2) ? 8'h00 : 8'h01;
  endfunction

  function automatic logic [8:0] period_of(input logic [1:0] m);
    case (m)
      2'd0:    return 9'd8;
      2'd1:    return 9'd14;
      2'd2:    return 9'd256;
      default: return 9'd255;
    endcase
  endfunction

  assign count_unused = currentCount;
  assign taps         = currentCount[15:12];
  assign tap          = taps[rate_sel];
  assign tick         = tap & ~prev_tap_q;
  assign step_inc     = {1'b0, step_q} + 9'd1;

  always_comb begin
    next_pat       = leds_q;
    next_dir_right = dir_right_q;
    case (mode_q)
      2'd0: next_pat = {leds_q[6:0], leds_q[7]};
      2'd1: begin
        // Direction flips on the step that lands on an end, so the end value is shown once.
        if (dir_right_q) begin
          next_pat = {1'b0, leds_q[7:1]};
          if (next_pat == 8'h01) next_dir_right = 1'b0;
        end else begin
          next_pat = {leds_q[6:0], 1'b0};
          if (next_pat == 8'h80) next_dir_right = 1'b1;
        end
      end
      2'd2: next_pat = leds_q + 8'd1;
      default: next_pat = {leds_q[6:0], leds_q[7] ^ leds_q[5] ^ leds_q[4] ^ leds_q[3]};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    leds_d      = leds_q;
    step_d      = step_q;
    mode_d      = mode_q;
    dir_right_d = dir_right_q;
    prev_tap_d  = tap;
    wrap_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (!stop && start) begin
          state_d     = RUN;
          mode_d      = mode;
          leds_d      = seed_of(mode);
          step_d      = '0;
          dir_right_d = 1'b0;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = HOLD;
        end else if (tick) begin
          if (step_inc == period_of(mode_q)) begin
            step_d      = '0;
            leds_d      = seed_of(mode_q);
            dir_right_d = 1'b0;
            wrap_d      = 1'b1;
          end else begin
            step_d      = step_inc[7:0];
            leds_d      = next_pat;
            dir_right_d = next_dir_right;
          end
        end
      end
      HOLD: begin
        if (stop) begin
          state_d     = IDLE;
          leds_d      = '0;
          step_d      = '0;
          dir_right_d = 1'b0;
        end else if (start) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        leds_d  = '0;
        step_d  = '0;
      end
    endcase

    busy_d    = (state_d != IDLE);
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      leds_q      <= '0;
      step_q      <= '0;
      mode_q      <= '0;
      dir_right_q <= 1'b0;
      prev_tap_q  <= 1'b0;
      wrap_q      <= 1'b0;
      busy_q      <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      leds_q      <= leds_d;
      step_q      <= step_d;
      mode_q      <= mode_d;
      dir_right_q <= dir_right_d;
      prev_tap_q  <= prev_tap_d;
      wrap_q      <= wrap_d;
      busy_q      <= busy_d;
      running_q   <= running_d;
    end
  end

  assign leds    = leds_q;
  assign busy    = busy_q;
  assign running = running_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: table-driven reference model checked every cycle,
// directed scenarios plus randomized counter/command stimulus.
module tb_led_sequencer;

  logic        clk;
  logic        rst_n;
  logic [15:0] currentCount;
  logic [1:0]  rate_sel;
  logic [1:0]  mode;
  logic        start;
  logic        stop;
  logic [7:0]  leds;
  logic        busy;
  logic        running;
  logic        wrap;

  int unsigned n_tests;
  int unsigned n_fail;

  // Reference model: pattern tables indexed by step, plus a coarse state.
  int seq_tbl [4][256];
  int period  [4];
  int m_st;      // 0 idle, 1 run, 2 hold
  int m_step;
  int m_mode;
  int m_prev;
  int m_wrap;

  led_sequencer #(.CNT_W(16), .LED_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .currentCount (currentCount),
    .rate_sel     (rate_sel),
    .mode         (mode),
    .start        (start),
    .stop         (stop),
    .leds         (leds),
    .busy         (busy),
    .running      (running),
    .wrap         (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic build_tables();
    int v;
    period = '{8, 14, 256, 255};
    v = 1;
    for (int k = 0; k < 256; k++) begin
      seq_tbl[0][k] = (1 << (k % 8));
      seq_tbl[1][k] = (k <= 7) ? (1 << k) : (1 << ((14 - k) % 8));
      seq_tbl[2][k] = k;
      seq_tbl[3][k] = v;
      v = ((v << 1) & 8'hFE) | (((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_step = 0; m_mode = 0; m_prev = 0; m_wrap = 0;
  endtask

  task automatic model_step();
    int tap;
    int tk;
    if (!rst_n) begin
      model_reset();
      return;
    end
    tap    = currentCount[12 + int'(rate_sel)];
    tk     = tap & ~m_prev;
    m_prev = tap;
    m_wrap = 0;
    case (m_st)
      0: if (!stop && start) begin m_st = 1; m_mode = mode; m_step = 0; end
      1: if (stop) m_st = 2;
         else if (tk) begin
           m_step++;
           if (m_step == period[m_mode]) begin m_step = 0; m_wrap = 1; end
         end
      default: if (stop) begin m_st = 0; m_step = 0; end
               else if (start) m_st = 1;
    endcase
  endtask

  function automatic int exp_leds();
    return (m_st == 0) ? 0 : seq_tbl[m_mode][m_step];
  endfunction

  task automatic check_all();
    check("leds",    leds,    exp_leds());
    check("busy",    busy,    m_st != 0);
    check("running", running, m_st == 1);
    check("wrap",    wrap,    m_wrap);
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic set_tap(input int v);
    logic [15:0] c;
    c = 16'($urandom);
    c[12 + int'(rate_sel)] = v[0];
    currentCount = c;
  endtask

  task automatic do_tick();
    set_tap(0); cycle();
    set_tap(1); cycle();
  endtask

  task automatic pulse_start(input int m);
    mode = 2'(m); start = 1'b1; set_tap(0); cycle(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cycle(); stop = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    build_tables();
    model_reset();
    rst_n = 1'b0; currentCount = '0; rate_sel = '0; mode = '0; start = 1'b0; stop = 1'b0;
    cycle(); cycle();
    check("rst_leds", leds, 8'h00);
    check("rst_busy", busy, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    cycle();

    // Rotate through one full period
    pulse_start(0);
    check("rot_seed", leds, 8'h01);
    for (int i = 0; i < 8; i++) do_tick();
    check("rot_end", leds, 8'h01);
    check("rot_wrap", wrap, 1'b1);
    pulse_stop(); pulse_stop();

    // Bounce through one full period
    pulse_start(1);
    for (int i = 0; i < 7; i++) do_tick();
    check("bnc_top", leds, 8'h80);
    do_tick();
    check("bnc_rev", leds, 8'h40);
    for (int i = 0; i < 6; i++) do_tick();
    check("bnc_end", leds, 8'h01);
    check("bnc_wrap", wrap, 1'b1);
    pulse_stop(); pulse_stop();

    // LFSR full period on a different tap
    rate_sel = 2'd3;
    pulse_start(3);
    for (int i = 0; i < 3; i++) do_tick();
    check("lfsr_3", leds, 8'h08);
    for (int i = 3; i < 255; i++) begin
      do_tick();
      if (leds == 8'h00) check("lfsr_zero", leds, 8'h01);
    end
    check("lfsr_end", leds, 8'h01);
    check("lfsr_wrap", wrap, 1'b1);
    pulse_stop(); pulse_stop();
    rate_sel = 2'd0;

    // Stop with coincident tick, hold, resume, clear
    pulse_start(0);
    do_tick(); do_tick();
    set_tap(0); cycle();
    set_tap(1); stop = 1'b1; cycle(); stop = 1'b0;
    check("hold_leds", leds, 8'h04);
    check("hold_run", running, 1'b0);
    check("hold_busy", busy, 1'b1);
    do_tick();
    check("hold_tick", leds, 8'h04);
    mode = 2'd2; start = 1'b1; set_tap(0); cycle(); start = 1'b0;
    do_tick();
    check("resume", leds, 8'h08);
    pulse_stop(); pulse_stop();
    check("clear", leds, 8'h00);

    // start+stop together: idle stays idle, run goes to hold
    start = 1'b1; stop = 1'b1; cycle(); start = 1'b0; stop = 1'b0;
    check("ss_idle", busy, 1'b0);
    pulse_start(0);
    for (int i = 0; i < 3; i++) do_tick();
    start = 1'b1; stop = 1'b1; cycle(); start = 1'b0; stop = 1'b0;
    check("ss_hold", leds, 8'h08);
    check("ss_run", running, 1'b0);
    pulse_stop(); pulse_stop();

    // Async reset mid-run, then tap already high after release
    pulse_start(0);
    for (int i = 0; i < 5; i++) do_tick();
    check("pre_rst", leds, 8'h20);
    #2 rst_n = 1'b0;
    #1;
    check("arst_leds", leds, 8'h00);
    check("arst_busy", busy, 1'b0);
    check("arst_run", running, 1'b0);
    model_reset();
    set_tap(1); cycle();
    @(negedge clk); rst_n = 1'b1;
    set_tap(1); cycle();
    set_tap(0); cycle();
    set_tap(1); cycle();
    check("post_rst", leds, 8'h00);

    // Randomized counter, rate, mode and commands
    for (int i = 0; i < 4000; i++) begin
      currentCount = 16'($urandom);
      if ($urandom_range(0, 15) == 0) rate_sel = 2'($urandom);
      mode  = 2'($urandom);
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
      end else begin
        cycle();
      end
    end
    start = 1'b0; stop = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
